id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath word width.
REQ-002 SHALL have parameter CNT_W, default 16, bubble-counter width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port ex_i  input  4  {RegDst, ALUOp[1:0], ALUSrc} from the decode control unit.
REQ-006 SHALL have port m_i  input  4  {Branch, MemRead, MemWrite, Jump} from the decode control unit.
REQ-007 SHALL have port wb_i  input  2  {RegWrite, MemtoReg} from the decode control unit.
REQ-008 SHALL have ports rd1_i, rd2_i, imm_i, pc4_i  input  DATA_W each  register-file reads, sign-extended immediate, PC+4.
REQ-009 SHALL have ports rs_i, rt_i, rd_i  input  5 each  decode-stage register specifiers.
REQ-010 SHALL have port flush_i  input  1  branch/jump taken; squash the decode instruction.
REQ-011 SHALL have port hold_i  input  1  global freeze (memory wait); all state keeps value.
REQ-012 SHALL have ports ex_o, m_o, wb_o  output  4/4/2  registered control bundles, same bit layout as inputs.
REQ-013 SHALL have ports rd1_o, rd2_o, imm_o, pc4_o  output  DATA_W each  registered data fields.
REQ-014 SHALL have ports rs_o, rt_o, rd_o  output  5 each  registered register specifiers.
REQ-015 SHALL have port valid_o  output  1  1 = real instruction in EX, 0 = bubble.
REQ-016 SHALL have port stall_o  output  1  combinational load-use stall to PC and IF/ID register (hold them).
REQ-017 SHALL have port bubbles_o  output  CNT_W  count of inserted bubbles.

Function
REQ-018 SHALL compute stall_o = m_o[2] & valid_o & (rt_o != 0) & (rt_o == rs_i | rt_o == rt_i) & ~flush_i & ~hold_i.
REQ-019 SHALL apply per-edge priority: rst > flush_i > hold_i > stall_o > normal load.
REQ-020 Normal load: all registered outputs take their inputs next edge, valid_o <= 1, latency exactly 1 cycle.
REQ-021 flush_i=1 (hold_i ignored): ex_o, m_o, wb_o <= 0, valid_o <= 0, data/specifier fields <= inputs, bubble counter increments.
REQ-022 hold_i=1 and flush_i=0: every register including bubbles_o keeps its value; stall_o forced 0.
REQ-023 stall_o=1: bubble loaded as in REQ-021 (controls 0, valid 0, counter +1); stall therefore lasts exactly one cycle because the bubble clears m_o[2].
REQ-024 Control inputs containing x SHALL never reach outputs during a bubble; bubble controls are hard 0.
REQ-025 Bubble counter SHALL saturate at all-ones and not wrap.
REQ-026 Register specifier 0 SHALL never cause a stall (REQ-018 rt_o != 0 term).
REQ-027 Back-to-back loads with dependence SHALL each produce one stall cycle; independent load followed by any instruction SHALL produce none.

Reset
REQ-028 While rst=1, asynchronously: all registered outputs 0, valid_o=0, bubbles_o=0; stall_o therefore 0.
REQ-029 Reset asserted mid-stall or mid-hold SHALL discard the pending bubble/held state; first edge after release performs a normal load.

Verification
REQ-030 Reset then ADD (ex_i=4'b1100, m_i=0, wb_i=2'b10, rd1_i=5, rd2_i=7) -> after 1 edge ex_o=4'b1100, wb_o=2'b10, rd1_o=5, valid_o=1, stall_o=0.
REQ-031 LW rt=8 loaded (m_o=4'b0100), decode presents rs_i=8 -> stall_o=1; next edge ex_o=m_o=wb_o=0, valid_o=0, bubbles_o=1; following cycle stall_o=0.
REQ-032 LW rt=0 loaded, decode rs_i=0 -> stall_o=0, no bubble.
REQ-033 flush_i=1 and hold_i=1 same cycle with BEQ inputs (ex_i=4'bx010) -> next edge controls 0, valid_o=0, bubbles_o+1, no x on outputs.
REQ-034 hold_i=1 for 3 cycles with changing inputs -> all outputs unchanged; stall_o=0 even with load-use pattern present.
REQ-035 Preset counter to all-ones via repeated flushes (CNT_W=4: 16 flushes) -> bubbles_o stays 4'hF; rst mid-sequence -> all outputs 0 immediately, no edge required.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush squash and global hold.
// Latency 1 cycle; stall_o is combinational and holds PC/IF-ID for exactly one cycle per load-use hazard.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        ex_i,
    input  logic [3:0]        m_i,
    input  logic [1:0]        wb_i,
    input  logic [DATA_W-1:0] rd1_i,
    input  logic [DATA_W-1:0] rd2_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [DATA_W-1:0] pc4_i,
    input  logic [4:0]        rs_i,
    input  logic [4:0]        rt_i,
    input  logic [4:0]        rd_i,
    input  logic              flush_i,
    input  logic              hold_i,
    output logic [3:0]        ex_o,
    output logic [3:0]        m_o,
    output logic [1:0]        wb_o,
    output logic [DATA_W-1:0] rd1_o,
    output logic [DATA_W-1:0] rd2_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [DATA_W-1:0] pc4_o,
    output logic [4:0]        rs_o,
    output logic [4:0]        rt_o,
    output logic [4:0]        rd_o,
    output logic              valid_o,
    output logic              stall_o,
    output logic [CNT_W-1:0]  bubbles_o
);

    logic [3:0]        r_ex;
    logic [3:0]        r_m;
    logic [1:0]        r_wb;
    logic [DATA_W-1:0] r_rd1;
    logic [DATA_W-1:0] r_rd2;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_pc4;
    logic [4:0]        r_rs;
    logic [4:0]        r_rt;
    logic [4:0]        r_rd;
    logic              r_valid;
    logic [CNT_W-1:0]  r_bubbles;

    logic              w_stall;
    logic              w_bubble;
    logic [CNT_W-1:0]  w_bubbles_inc;

    // Load in EX whose destination is read by the decode instruction; $zero never hazards.
    assign w_stall = r_m[2] & r_valid & (r_rt != 5'd0) &
                     ((r_rt == rs_i) | (r_rt == rt_i)) & ~flush_i & ~hold_i;

    assign w_bubble      = flush_i | w_stall;
    assign w_bubbles_inc = (r_bubbles == {CNT_W{1'b1}}) ? r_bubbles : r_bubbles + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex      <= '0;
            r_m       <= '0;
            r_wb      <= '0;
            r_rd1     <= '0;
            r_rd2     <= '0;
            r_imm     <= '0;
            r_pc4     <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_rd      <= '0;
            r_valid   <= 1'b0;
            r_bubbles <= '0;
        end else if (flush_i || !hold_i) begin
            r_rd1 <= rd1_i;
            r_rd2 <= rd2_i;
            r_imm <= imm_i;
            r_pc4 <= pc4_i;
            r_rs  <= rs_i;
            r_rt  <= rt_i;
            r_rd  <= rd_i;
            if (w_bubble) begin
                r_ex      <= '0;
                r_m       <= '0;
                r_wb      <= '0;
                r_valid   <= 1'b0;
                r_bubbles <= w_bubbles_inc;
            end else begin
                r_ex    <= ex_i;
                r_m     <= m_i;
                r_wb    <= wb_i;
                r_valid <= 1'b1;
            end
        end
    end

    assign ex_o      = r_ex;
    assign m_o       = r_m;
    assign wb_o      = r_wb;
    assign rd1_o     = r_rd1;
    assign rd2_o     = r_rd2;
    assign imm_o     = r_imm;
    assign pc4_o     = r_pc4;
    assign rs_o      = r_rs;
    assign rt_o      = r_rt;
    assign rd_o      = r_rd;
    assign valid_o   = r_valid;
    assign stall_o   = w_stall;
    assign bubbles_o = r_bubbles;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage (CNT_W=4 so counter saturation is reachable quickly).
module tb_id_ex_stage;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst;
    logic [3:0]        ex_i, m_i;
    logic [1:0]        wb_i;
    logic [DATA_W-1:0] rd1_i, rd2_i, imm_i, pc4_i;
    logic [4:0]        rs_i, rt_i, rd_i;
    logic              flush_i, hold_i;
    logic [3:0]        ex_o, m_o;
    logic [1:0]        wb_o;
    logic [DATA_W-1:0] rd1_o, rd2_o, imm_o, pc4_o;
    logic [4:0]        rs_o, rt_o, rd_o;
    logic              valid_o, stall_o;
    logic [CNT_W-1:0]  bubbles_o;

    int checks = 0;
    int errors = 0;

    id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .ex_i(ex_i), .m_i(m_i), .wb_i(wb_i),
        .rd1_i(rd1_i), .rd2_i(rd2_i), .imm_i(imm_i), .pc4_i(pc4_i),
        .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i),
        .flush_i(flush_i), .hold_i(hold_i),
        .ex_o(ex_o), .m_o(m_o), .wb_o(wb_o),
        .rd1_o(rd1_o), .rd2_o(rd2_o), .imm_o(imm_o), .pc4_o(pc4_o),
        .rs_o(rs_o), .rt_o(rt_o), .rd_o(rd_o),
        .valid_o(valid_o), .stall_o(stall_o), .bubbles_o(bubbles_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a decode-stage instruction (inputs only; no checking).
    task automatic drive(input logic [3:0] ex, input logic [3:0] m, input logic [1:0] wb,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] d1, input logic [31:0] d2);
        ex_i = ex; m_i = m; wb_i = wb;
        rs_i = rs; rt_i = rt; rd_i = rd;
        rd1_i = d1; rd2_i = d2; imm_i = d1 + 32'h100; pc4_i = d2 + 32'h200;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush_i = 1'b0; hold_i = 1'b0;
        drive(4'hF, 4'hF, 2'b11, 5'd8, 5'd8, 5'd8, 32'hDEAD_BEEF, 32'h1234_5678);
        #12;
        checks++;
        if ({ex_o, m_o, wb_o, valid_o, stall_o, bubbles_o} !== '0 ||
            {rd1_o, rd2_o, imm_o, pc4_o, rs_o, rt_o, rd_o} !== '0) begin
            errors++;
            $display("FAIL reset_state: ex=%b m=%b wb=%b v=%b st=%b bub=%0d rd1=%h expected all 0",
                     ex_o, m_o, wb_o, valid_o, stall_o, bubbles_o, rd1_o);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add();
        drive(4'b1100, 4'b0000, 2'b10, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
        tick();
        checks++;
        if ({ex_o, m_o, wb_o, valid_o, stall_o} !== {4'b1100, 4'b0000, 2'b10, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL add_ctrl: ex=%b m=%b wb=%b v=%b st=%b expected 1100 0000 10 1 0",
                     ex_o, m_o, wb_o, valid_o, stall_o);
        end
        checks++;
        if ({rd1_o, rd2_o, imm_o, pc4_o, rs_o, rt_o, rd_o, bubbles_o} !==
            {32'd5, 32'd7, 32'h105, 32'h207, 5'd1, 5'd2, 5'd3, 4'd0}) begin
            errors++;
            $display("FAIL add_data: rd1=%0d rd2=%0d imm=%h pc4=%h rs=%0d rt=%0d rd=%0d bub=%0d expected 5 7 105 207 1 2 3 0",
                     rd1_o, rd2_o, imm_o, pc4_o, rs_o, rt_o, rd_o, bubbles_o);
        end
    endtask

    task automatic test_load_use();
        drive(4'b0001, 4'b0100, 2'b11, 5'd2, 5'd8, 5'd0, 32'd40, 32'd0);
        tick();
        checks++;
        if ({m_o, rt_o, valid_o} !== {4'b0100, 5'd8, 1'b1}) begin
            errors++;
            $display("FAIL lw_load: m=%b rt=%0d v=%b expected 0100 8 1", m_o, rt_o, valid_o);
        end
        drive(4'b1100, 4'b0000, 2'b10, 5'd8, 5'd3, 5'd4, 32'd11, 32'd12);
        #1;
        checks++;
        if (stall_o !== 1'b1) begin
            errors++;
            $display("FAIL load_use_stall: stall=%b expected 1", stall_o);
        end
        tick();
        checks++;
        if ({ex_o, m_o, wb_o, valid_o, bubbles_o, stall_o} !==
            {4'b0, 4'b0, 2'b0, 1'b0, 4'd1, 1'b0}) begin
            errors++;
            $display("FAIL load_use_bubble: ex=%b m=%b wb=%b v=%b bub=%0d st=%b expected 0 0 0 0 1 0",
                     ex_o, m_o, wb_o, valid_o, bubbles_o, stall_o);
        end
        tick();
        checks++;
        if ({ex_o, valid_o, rs_o, bubbles_o} !== {4'b1100, 1'b1, 5'd8, 4'd1}) begin
            errors++;
            $display("FAIL load_use_reissue: ex=%b v=%b rs=%0d bub=%0d expected 1100 1 8 1",
                     ex_o, valid_o, rs_o, bubbles_o);
        end
    endtask

    task automatic test_rt_zero();
        drive(4'b0001, 4'b0100, 2'b11, 5'd2, 5'd0, 5'd0, 32'd1, 32'd2);
        tick();
        drive(4'b1100, 4'b0000, 2'b10, 5'd0, 5'd0, 5'd5, 32'd3, 32'd4);
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL rt_zero_stall: stall=%b expected 0", stall_o);
        end
        tick();
        checks++;
        if ({valid_o, ex_o, bubbles_o} !== {1'b1, 4'b1100, 4'd1}) begin
            errors++;
            $display("FAIL rt_zero_load: v=%b ex=%b bub=%0d expected 1 1100 1", valid_o, ex_o, bubbles_o);
        end
    endtask

    task automatic test_back_to_back();
        drive(4'b0001, 4'b0100, 2'b11, 5'd1, 5'd5, 5'd0, 32'd0, 32'd0);
        tick();
        drive(4'b0001, 4'b0100, 2'b11, 5'd5, 5'd6, 5'd0, 32'd0, 32'd0);
        #1;
        checks++;
        if (stall_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_stall1: stall=%b expected 1", stall_o);
        end
        tick();
        checks++;
        if ({valid_o, bubbles_o, stall_o} !== {1'b0, 4'd2, 1'b0}) begin
            errors++;
            $display("FAIL b2b_bubble1: v=%b bub=%0d st=%b expected 0 2 0", valid_o, bubbles_o, stall_o);
        end
        tick();
        drive(4'b1100, 4'b0000, 2'b10, 5'd6, 5'd9, 5'd10, 32'd0, 32'd0);
        #1;
        checks++;
        if ({m_o, rt_o, stall_o} !== {4'b0100, 5'd6, 1'b1}) begin
            errors++;
            $display("FAIL b2b_stall2: m=%b rt=%0d st=%b expected 0100 6 1", m_o, rt_o, stall_o);
        end
        tick();
        checks++;
        if ({valid_o, bubbles_o} !== {1'b0, 4'd3}) begin
            errors++;
            $display("FAIL b2b_bubble2: v=%b bub=%0d expected 0 3", valid_o, bubbles_o);
        end
        tick();
        drive(4'b0001, 4'b0100, 2'b11, 5'd1, 5'd7, 5'd0, 32'd0, 32'd0);
        tick();
        drive(4'b1100, 4'b0000, 2'b10, 5'd1, 5'd2, 5'd3, 32'd0, 32'd0);
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL indep_no_stall: stall=%b expected 0", stall_o);
        end
        tick();
        checks++;
        if ({valid_o, ex_o, bubbles_o} !== {1'b1, 4'b1100, 4'd3}) begin
            errors++;
            $display("FAIL indep_load: v=%b ex=%b bub=%0d expected 1 1100 3", valid_o, ex_o, bubbles_o);
        end
    endtask

    task automatic test_flush_hold();
        drive(4'bx010, 4'b1000, 2'b00, 5'd4, 5'd5, 5'd0, 32'h0000_00AA, 32'h0000_00BB);
        flush_i = 1'b1; hold_i = 1'b1;
        tick();
        flush_i = 1'b0; hold_i = 1'b0;
        checks++;
        if ({ex_o, m_o, wb_o, valid_o, bubbles_o} !== {4'b0, 4'b0, 2'b0, 1'b0, 4'd4}) begin
            errors++;
            $display("FAIL flush_hold_ctrl: ex=%b m=%b wb=%b v=%b bub=%0d expected 0 0 0 0 4",
                     ex_o, m_o, wb_o, valid_o, bubbles_o);
        end
        checks++;
        if ({rd1_o, rs_o, rt_o} !== {32'h0000_00AA, 5'd4, 5'd5}) begin
            errors++;
            $display("FAIL flush_data: rd1=%h rs=%0d rt=%0d expected aa 4 5", rd1_o, rs_o, rt_o);
        end
    endtask

    task automatic test_hold();
        drive(4'b0001, 4'b0100, 2'b11, 5'd3, 5'd9, 5'd0, 32'h55, 32'h66);
        tick();
        hold_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(4'b1100, 4'b0000, 2'b10, 5'd9, 5'(i), 5'(i + 1), 32'(i * 3 + 1), 32'(i));
            #1;
            checks++;
            if (stall_o !== 1'b0) begin
                errors++;
                $display("FAIL hold_stall_forced0: cycle=%0d stall=%b expected 0", i, stall_o);
            end
            tick();
            checks++;
            if ({ex_o, m_o, wb_o, valid_o, rt_o, rs_o, rd1_o, bubbles_o} !==
                {4'b0001, 4'b0100, 2'b11, 1'b1, 5'd9, 5'd3, 32'h55, 4'd4}) begin
                errors++;
                $display("FAIL hold_keep: cycle=%0d ex=%b m=%b wb=%b v=%b rt=%0d rs=%0d rd1=%h bub=%0d expected 0001 0100 11 1 9 3 55 4",
                         i, ex_o, m_o, wb_o, valid_o, rt_o, rs_o, rd1_o, bubbles_o);
            end
        end
        hold_i = 1'b0;
        #1;
        checks++;
        if (stall_o !== 1'b1) begin
            errors++;
            $display("FAIL hold_release_stall: stall=%b expected 1", stall_o);
        end
        tick();
    endtask

    task automatic test_saturate_reset();
        logic [CNT_W-1:0] exp_bub;
        exp_bub = bubbles_o == 4'd5 ? 4'd5 : 4'd5;
        // The hold-release stall above inserted bubble #5.
        checks++;
        if (bubbles_o !== 4'd5) begin
            errors++;
            $display("FAIL pre_saturate_count: bub=%0d expected 5", bubbles_o);
        end
        flush_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(4'b1100, 4'b0000, 2'b10, 5'd1, 5'd2, 5'd3, 32'(i), 32'(i));
            tick();
            exp_bub = (exp_bub == 4'hF) ? 4'hF : exp_bub + 4'd1;
            checks++;
            if (bubbles_o !== exp_bub) begin
                errors++;
                $display("FAIL saturate_step: flush=%0d bub=%0d expected %0d", i, bubbles_o, exp_bub);
            end
        end
        flush_i = 1'b0;
        drive(4'b0001, 4'b0100, 2'b11, 5'd1, 5'd8, 5'd0, 32'h77, 32'h88);
        tick();
        drive(4'b1100, 4'b0000, 2'b10, 5'd8, 5'd2, 5'd3, 32'h99, 32'hAA);
        #1;
        checks++;
        if ({stall_o, bubbles_o} !== {1'b1, 4'hF}) begin
            errors++;
            $display("FAIL pre_reset_stall: st=%b bub=%0d expected 1 15", stall_o, bubbles_o);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({ex_o, m_o, wb_o, valid_o, stall_o, bubbles_o, rd1_o, rt_o} !== '0) begin
            errors++;
            $display("FAIL async_reset: ex=%b m=%b wb=%b v=%b st=%b bub=%0d rd1=%h rt=%0d expected all 0",
                     ex_o, m_o, wb_o, valid_o, stall_o, bubbles_o, rd1_o, rt_o);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++;
        if ({ex_o, valid_o, rs_o, rd1_o, bubbles_o} !== {4'b1100, 1'b1, 5'd8, 32'h99, 4'd0}) begin
            errors++;
            $display("FAIL post_reset_load: ex=%b v=%b rs=%0d rd1=%h bub=%0d expected 1100 1 8 99 0",
                     ex_o, valid_o, rs_o, rd1_o, bubbles_o);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_load_use();
        test_rt_zero();
        test_back_to_back();
        test_flush_hold();
        test_hold();
        test_saturate_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
